reg_skid_2l_sclr: RTL
=====================

REG_SKID_2L_SCLR -- requirements
Module: reg_skid_2l_sclr

Interface
REQ-001 Parameter DATA_WIDTH, default 1: width of the data path in bits.
REQ-002 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 Port sclr, input, 1: synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 Port in_valid, input, 1: upstream presents a word on in_data.
REQ-005 Port in_ready, output, 1: block accepts a word this cycle.
REQ-006 Port in_data, input, DATA_WIDTH: upstream word.
REQ-007 Port out_valid, output, 1: out_data holds a valid word.
REQ-008 Port out_ready, output side handshake input, 1: downstream accepts out_data this cycle.
REQ-009 Port out_data, output, DATA_WIDTH: head word.
REQ-010 Port level, output, 2: occupancy 0..2; present only with REG_SKID_LEVEL_EN.

Function
REQ-011 Block is the backpressure-aware receiving end of a 2-register delay pipeline: a 2-entry elastic buffer, head register plus skid register.
REQ-012 Push occurs when in_valid=1 and in_ready=1 at a rising edge; pop occurs when out_valid=1 and out_ready=1 at a rising edge.
REQ-013 State machine with states EMPTY (0 words), ONE (1 word), FULL (2 words); occupancy held in a 2-bit count.
REQ-014 EMPTY: push -> ONE, head<=in_data; no push -> stay EMPTY.
REQ-015 ONE: push and pop -> stay ONE, head<=in_data; push only -> FULL, skid<=in_data; pop only -> EMPTY; neither -> stay ONE.
REQ-016 FULL: pop -> ONE, head<=skid; no pop -> stay FULL, head and skid unchanged.
REQ-017 in_ready is a registered output equal to 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-018 out_valid is a registered output equal to 1 in ONE and FULL, 0 in EMPTY; out_data is driven directly from the head register.
REQ-019 Latency: a word pushed at edge N is presented on out_data with out_valid=1 after edge N when the buffer was EMPTY; otherwise it waits behind older words.
REQ-020 Throughput: one word per cycle sustained when out_ready is held at 1.
REQ-021 Words leave in push order; no word is dropped or duplicated.
REQ-022 in_valid while in_ready=0 is ignored; in_data is not captured.
REQ-023 While out_valid=1 and out_ready=0, out_data is held stable.
REQ-024 out_ready while out_valid=0 has no effect.

Reset
REQ-025 sclr=1 at an edge: state EMPTY, count 0, head and skid 0, out_valid 0, in_ready 1, out_data 0, level 0.
REQ-026 sclr has priority over push and pop in the same cycle; words held before reset are discarded.
REQ-027 Reset asserted mid-stream, including in FULL, yields the REQ-025 values on the next cycle with no further words emitted.

Configuration
REQ-028 Macro REG_SKID_LEVEL_EN defined: port level present and equal to the registered count (0, 1 or 2).
REQ-029 Macro REG_SKID_LEVEL_EN undefined: port level absent; all other behaviour identical.

Verification
REQ-030 Reset then idle: after sclr pulse -> out_valid=0, in_ready=1, out_data=0, level=0.
REQ-031 Streaming, DATA_WIDTH=8, out_ready=1, push 0x01..0x10 back-to-back -> out_data 0x01..0x10 on consecutive cycles, each one cycle after its push, in_ready stays 1.
REQ-032 Backpressure: out_ready=0, push 0xA1, 0xA2, 0xA3 -> after two pushes in_ready=0, level=2, 0xA3 held off upstream; raise out_ready -> output 0xA1, 0xA2, 0xA3 in order, no loss.
REQ-033 Stall stability: out_valid=1, out_ready=0 for 5 cycles with in_valid toggling -> out_data unchanged all 5 cycles.
REQ-034 Reset in FULL: hold 0x55, 0x66, assert sclr one cycle -> next cycle out_valid=0, in_ready=1, level=0; neither word emitted.
REQ-035 Random in_valid/out_ready at 50% for 10000 cycles -> scoreboard shows ordered, lossless, duplicate-free transfer.

Source files
------------

// File: rtl/reg_skid_2l_sclr.sv
// Two-entry elastic buffer with a head and a skid register, registered ready/valid, synchronous clear.
// Define REG_SKID_LEVEL_EN to expose the occupancy count on port `level`.
module reg_skid_2l_sclr #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef REG_SKID_LEVEL_EN
    ,
    output logic [1:0]            level
`endif
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic push;
    logic pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // State register. The data registers are cleared too because out_data
    // must read as zero after a clear.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath.
    // NOTE: defaults first so every path assigns every signal (no latches).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    head_d  = in_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state and registered, so
    // out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;

`ifdef REG_SKID_LEVEL_EN
    assign level = state_q;
`endif

endmodule
